sd_sector_buffer: RTL and testbench

- Upstream feeder for the SD SPI sector writer.
- Accepts a byte stream from the acquisition/UART side and packs it into 16-bit words, MSB byte first.
- Stores the words in two ping-pong 256-word sector banks.
- Issues one sector write per full bank and supplies each word on the writer's wr_req, incrementing the sector address after each completed sector.

---
 rtl/sd_sector_buffer.sv | 227 ++++++++++++++++++++++
 tb/tb_sd_sector_buffer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_sector_buffer.sv
// sd_sector_buffer: packs a byte stream into 16-bit words (MSB first) across two 256-word
// ping-pong banks and feeds one SD sector write per full bank. SD_SECBUF_FLUSH_EN adds pad-flush.
module sd_sector_buffer #(
    parameter logic [31:0] START_SEC = 32'd0,
    parameter logic [31:0] SEC_LIMIT = 32'd65536,
    parameter logic [7:0]  FILL_BYTE = 8'hFF
) (
    input  logic        clk_sd,
    input  logic        reset,
    input  logic [7:0]  din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic        wr_start_en,
    output logic [31:0] wr_sec_addr,
    output logic [15:0] wr_data,
    input  logic        wr_busy,
    input  logic        wr_req,
    output logic [31:0] sec_cnt,
    output logic        overflow,
`ifdef SD_SECBUF_FLUSH_EN
    input  logic        flush,
    output logic        flush_busy,
`endif
    output logic        done
);

    localparam int unsigned PTR_W  = 8;
    localparam int unsigned ADDR_W = PTR_W + 1;
    localparam int unsigned WORD_W = 16;

    typedef enum logic [2:0] {IDLE, PRELOAD, START, XFER, WAIT_END} state_t;

    state_t             state_q, state_d;
    logic [1:0]         full_q, full_d;
    logic               fill_q, fill_d, drain_q, drain_d;
    logic               phase_q, phase_d;
    logic [7:0]         hi_q, hi_d;
    logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d, req_cnt_q, req_cnt_d;
    logic [1:0]         hold_q, hold_d;
    logic               ld_q, ld_d;
    logic               din_ready_q, din_ready_d;
    logic               wr_start_en_q, wr_start_en_d;
    logic [31:0]        addr_q, addr_d, sec_cnt_q, sec_cnt_d;
    logic [WORD_W-1:0]  wr_data_q, wr_data_d;
    logic               overflow_q, overflow_d, done_q, done_d;
`ifdef SD_SECBUF_FLUSH_EN
    logic               flush_q, flush_d;
`endif

    logic [WORD_W-1:0]  mem [2**ADDR_W];
    logic [WORD_W-1:0]  rd_word_q;
    logic               flushing_c, byte_v_c, we_c;
    logic [7:0]         byte_c;
    logic [ADDR_W-1:0]  waddr_c, rd_addr_c;
    logic [WORD_W-1:0]  wdata_c;

`ifdef SD_SECBUF_FLUSH_EN
    assign flushing_c = flush_q;
`else
    assign flushing_c = 1'b0;
`endif
    // While flushing, pad bytes take the place of accepted input bytes.
    assign byte_v_c = (din_valid & din_ready_q) | flushing_c;
    assign byte_c   = flushing_c ? FILL_BYTE : din;

    always_comb begin
        state_d       = state_q;
        full_d        = full_q;
        fill_d        = fill_q;
        drain_d       = drain_q;
        phase_d       = phase_q;
        hi_d          = hi_q;
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        req_cnt_d     = req_cnt_q;
        hold_d        = hold_q;
        ld_d          = 1'b0;
        wr_start_en_d = wr_start_en_q;
        addr_d        = addr_q;
        sec_cnt_d     = sec_cnt_q;
        done_d        = done_q;
        wr_data_d     = ld_q ? rd_word_q : wr_data_q;
        overflow_d    = overflow_q | (din_valid & ~din_ready_q);
        we_c          = 1'b0;
        waddr_c       = {fill_q, wptr_q};
        wdata_c       = {hi_q, byte_c};
        rd_addr_c     = {drain_q, rptr_q};
`ifdef SD_SECBUF_FLUSH_EN
        flush_d       = flush_q;
`endif

        // Fill side: pair bytes into words; a full bank hands over to the other once it is free.
        if (byte_v_c) begin
            if (!phase_q) begin
                hi_d    = byte_c;
                phase_d = 1'b1;
            end else begin
                we_c    = 1'b1;
                phase_d = 1'b0;
                wptr_d  = wptr_q + PTR_W'(1);
                if (wptr_q == '1) begin
                    full_d[fill_q] = 1'b1;
`ifdef SD_SECBUF_FLUSH_EN
                    flush_d = 1'b0;
`endif
                    if (!full_q[~fill_q]) fill_d = ~fill_q;
                end
            end
        end else if (full_q[fill_q] && !full_q[~fill_q]) begin
            fill_d = ~fill_q;
        end

        case (state_q)
            IDLE: if (full_q[drain_q] && !done_q) state_d = PRELOAD;
            PRELOAD: begin
                rd_addr_c     = {drain_q, PTR_W'(0)};
                ld_d          = 1'b1;
                rptr_d        = PTR_W'(1);
                req_cnt_d     = '0;
                hold_d        = '0;
                wr_start_en_d = 1'b1;
                state_d       = START;
            end
            // Start level must stay up for at least three cycles and until busy is seen.
            START: begin
                if (hold_q != 2'd2) hold_d = hold_q + 2'd1;
                if (wr_busy && hold_q == 2'd2) begin
                    wr_start_en_d = 1'b0;
                    state_d       = XFER;
                end
            end
            XFER: begin
                if (wr_req) begin
                    ld_d      = 1'b1;
                    rptr_d    = rptr_q + PTR_W'(1);
                    req_cnt_d = req_cnt_q + PTR_W'(1);
                    if (req_cnt_q == '1) state_d = WAIT_END;
                end else if (!wr_busy) begin
                    state_d = IDLE;
                end
            end
            WAIT_END: begin
                if (!wr_busy) begin
                    full_d[drain_q] = 1'b0;
                    drain_d         = ~drain_q;
                    addr_d          = addr_q + 32'd1;
                    sec_cnt_d       = sec_cnt_q + 32'd1;
                    if (SEC_LIMIT != 32'd0 && sec_cnt_d == SEC_LIMIT) done_d = 1'b1;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef SD_SECBUF_FLUSH_EN
        if (!flush_q && flush && (wptr_d != '0 || phase_d)) flush_d = 1'b1;
        din_ready_d = ~full_d[fill_d] & ~done_d & ~flush_d;
`else
        din_ready_d = ~full_d[fill_d] & ~done_d;
`endif
    end

    always_ff @(posedge clk_sd) begin
        if (we_c) mem[waddr_c] <= wdata_c;
        rd_word_q <= mem[rd_addr_c];
    end

    always_ff @(posedge clk_sd) begin
        if (reset) begin
            state_q       <= IDLE;
            full_q        <= '0;
            fill_q        <= 1'b0;
            drain_q       <= 1'b0;
            phase_q       <= 1'b0;
            hi_q          <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            req_cnt_q     <= '0;
            hold_q        <= '0;
            ld_q          <= 1'b0;
            din_ready_q   <= 1'b1;
            wr_start_en_q <= 1'b0;
            addr_q        <= START_SEC;
            sec_cnt_q     <= '0;
            wr_data_q     <= '0;
            overflow_q    <= 1'b0;
            done_q        <= 1'b0;
`ifdef SD_SECBUF_FLUSH_EN
            flush_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            full_q        <= full_d;
            fill_q        <= fill_d;
            drain_q       <= drain_d;
            phase_q       <= phase_d;
            hi_q          <= hi_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            req_cnt_q     <= req_cnt_d;
            hold_q        <= hold_d;
            ld_q          <= ld_d;
            din_ready_q   <= din_ready_d;
            wr_start_en_q <= wr_start_en_d;
            addr_q        <= addr_d;
            sec_cnt_q     <= sec_cnt_d;
            wr_data_q     <= wr_data_d;
            overflow_q    <= overflow_d;
            done_q        <= done_d;
`ifdef SD_SECBUF_FLUSH_EN
            flush_q       <= flush_d;
`endif
        end
    end

    assign din_ready   = din_ready_q;
    assign wr_start_en = wr_start_en_q;
    assign wr_sec_addr = addr_q;
    assign wr_data     = wr_data_q;
    assign sec_cnt     = sec_cnt_q;
    assign overflow    = overflow_q;
    assign done        = done_q;
`ifdef SD_SECBUF_FLUSH_EN
    assign flush_busy  = flush_q;
`endif

endmodule

// File: tb/tb_sd_sector_buffer.sv
// tb_sd_sector_buffer: directed bench for sd_sector_buffer with a behavioural SD sector-writer
// model; START_SEC sits at 2^32-1 so the sector address wraps during multi-sector runs.
`timescale 1ns/1ps
module tb_sd_sector_buffer;
    localparam logic [31:0] S   = 32'hFFFF_FFFF;
    localparam logic [31:0] LIM = 32'd3;

    logic        clk_sd = 1'b0;
    logic        reset, din_valid, wr_busy, wr_req;
    logic [7:0]  din;
    logic        din_ready, wr_start_en, overflow, done;
    logic [31:0] wr_sec_addr, sec_cnt;
    logic [15:0] wr_data;
`ifdef SD_SECBUF_FLUSH_EN
    logic        flush, flush_busy;
`endif

    int n_vec = 0, n_err = 0;

    sd_sector_buffer #(.START_SEC(S), .SEC_LIMIT(LIM), .FILL_BYTE(8'hFF)) dut (
        .clk_sd(clk_sd), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .wr_start_en(wr_start_en), .wr_sec_addr(wr_sec_addr), .wr_data(wr_data),
        .wr_busy(wr_busy), .wr_req(wr_req), .sec_cnt(sec_cnt), .overflow(overflow),
`ifdef SD_SECBUF_FLUSH_EN
        .flush(flush), .flush_busy(flush_busy),
`endif
        .done(done)
    );

    always #5 clk_sd = ~clk_sd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Stream byte i; the sector index is folded in so every sector carries distinct data.
    function automatic logic [7:0] byte_of(input int i);
        return 8'(i) + 8'(i >> 9);
    endfunction

    // Writer model state and capture queues
    bit          w_en;
    int          w_busy_dly, w_gap, w_abort, w_starts, w_done;
    logic [31:0] cap_addr[$];
    int          cap_len[$], cap_hold[$];
    logic [15:0] cap_w[$];

    initial begin : writer
        int n, hold;
        wr_busy = 1'b0;
        wr_req  = 1'b0;
        forever begin
            @(negedge clk_sd);
            if (w_en && wr_start_en && !reset) begin
                cap_addr.push_back(wr_sec_addr);
                w_starts++;
                hold = 1;
                repeat (w_busy_dly) begin
                    @(negedge clk_sd);
                    if (wr_start_en) hold++;
                end
                wr_busy = 1'b1;
                for (int t = 0; t < 50 && wr_start_en; t++) begin
                    @(negedge clk_sd);
                    if (wr_start_en) hold++;
                end
                cap_hold.push_back(hold);
                n = 0;
                while (n < 256 && !(w_abort != 0 && n == w_abort)) begin
                    repeat (w_gap) @(negedge clk_sd);
                    cap_w.push_back(wr_data);
                    wr_req = 1'b1;
                    @(negedge clk_sd);
                    wr_req = 1'b0;
                    n++;
                end
                if (n == w_abort) w_abort = 0;
                repeat (2) @(negedge clk_sd);
                wr_busy = 1'b0;
                cap_len.push_back(n);
                if (n == 256) w_done++;
            end
        end
    end

    int fd_acc, fd_stall, fd_tot;

    task automatic feed(input int first, input int n, input int mark, input int budget);
        int cyc = 0;
        fd_acc = 0; fd_stall = 0; fd_tot = 0;
        while (fd_acc < n && cyc < budget) begin
            @(negedge clk_sd);
            if (din_ready) begin
                din = byte_of(first + fd_acc);
                din_valid = 1'b1;
                fd_acc++;
            end else begin
                din_valid = 1'b0;
                fd_tot++;
                if (fd_acc < mark) fd_stall++;
            end
            cyc++;
        end
        @(negedge clk_sd);
        din_valid = 1'b0;
    endtask

    task automatic wait_sectors(input string tag, input int k, input int budget);
        int t = 0;
        while (w_done < k && t < budget) begin
            @(negedge clk_sd);
            t++;
        end
        chk(tag, 32'(w_done), 32'(k));
        repeat (3) @(negedge clk_sd);
    endtask

    task automatic chk_sector(input string tag, input int idx, input int s, input int nw);
        int bad = 0;
        chk({tag, "_avail"}, 32'(cap_w.size() >= idx + nw), 32'd1);
        if (cap_w.size() >= idx + nw) begin
            for (int w = 0; w < nw; w++)
                if (cap_w[idx + w] !== {byte_of(512 * s + 2 * w), byte_of(512 * s + 2 * w + 1)}) bad++;
            chk({tag, "_w0"}, 32'(cap_w[idx]), 32'({byte_of(512 * s), byte_of(512 * s + 1)}));
        end
        chk({tag, "_bad_words"}, 32'(bad), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1; din_valid = 1'b0; din = 8'h00; w_en = 1'b0;
`ifdef SD_SECBUF_FLUSH_EN
        flush = 1'b0;
`endif
        w_busy_dly = 2; w_gap = 1; w_abort = 0;
        repeat (3) @(negedge clk_sd);
        reset = 1'b0;
        cap_w.delete(); cap_addr.delete(); cap_len.delete(); cap_hold.delete();
        w_starts = 0; w_done = 0;
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int t;
        // Reset values and single sector
        do_reset();
        chk("rst_din_ready", 32'(din_ready), 32'd1);
        chk("rst_start_en", 32'(wr_start_en), 32'd0);
        chk("rst_sec_addr", wr_sec_addr, S);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_sec_cnt", sec_cnt, 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        w_en = 1'b1;
        feed(0, 512, 0, 2000);
        chk("t1_fed", 32'(fd_acc), 32'd512);
        wait_sectors("t1_wait", 1, 3000);
        chk("t1_starts", 32'(w_starts), 32'd1);
        chk("t1_addr", cap_addr[0], S);
        chk("t1_hold", 32'(cap_hold[0]), 32'd3);
        chk_sector("t1", 0, 0, 256);
        chk("t1_sec_cnt", sec_cnt, 32'd1);
        chk("t1_addr_next", wr_sec_addr, S + 32'd1);

        // Ping-pong with a slow writer
        do_reset();
        w_en = 1'b1; w_busy_dly = 5; w_gap = 4;
        feed(0, 1536, 1024, 20000);
        chk("t2_fed", 32'(fd_acc), 32'd1536);
        chk("t2_early_stall", 32'(fd_stall), 32'd0);
        chk("t2_stalled", 32'(fd_tot > 0), 32'd1);
        wait_sectors("t2_wait", 3, 20000);
        chk("t2_addr0", cap_addr[0], S);
        chk("t2_addr1", cap_addr[1], S + 32'd1);
        chk("t2_addr2", cap_addr[2], S + 32'd2);
        chk("t2_hold", 32'(cap_hold[0]), 32'd6);
        chk_sector("t2s0", 0, 0, 256);
        chk_sector("t2s1", 256, 1, 256);
        chk_sector("t2s2", 512, 2, 256);
        chk("t2_sec_cnt", sec_cnt, 32'd3);
        chk("t2_done", 32'(done), 32'd1);

        // Overflow with both banks full
        do_reset();
        feed(0, 1024, 1024, 1100);
        chk("t3_fed", 32'(fd_acc), 32'd1024);
        chk("t3_ready_low", 32'(din_ready), 32'd0);
        chk("t3_no_ovf_yet", 32'(overflow), 32'd0);
        chk("t3_start_held", 32'(wr_start_en), 32'd1);
        din = 8'hEE; din_valid = 1'b1;
        @(negedge clk_sd);
        din_valid = 1'b0;
        repeat (3) @(negedge clk_sd);
        chk("t3_ovf_set", 32'(overflow), 32'd1);
        w_en = 1'b1;
        wait_sectors("t3_wait", 2, 5000);
        chk_sector("t3s0", 0, 0, 256);
        chk_sector("t3s1", 256, 1, 256);
        chk("t3_ovf_sticky", 32'(overflow), 32'd1);

        // Writer abort after 100 requests and retry
        do_reset();
        w_en = 1'b1; w_abort = 100;
        feed(0, 512, 0, 2000);
        t = 0;
        while (w_starts < 2 && t < 3000) begin
            @(negedge clk_sd);
            t++;
        end
        chk("t4_restarted", 32'(w_starts), 32'd2);
        chk("t4_cnt_kept", sec_cnt, 32'd0);
        chk("t4_addr_kept", wr_sec_addr, S);
        wait_sectors("t4_wait", 1, 3000);
        chk("t4_len0", 32'(cap_len[0]), 32'd100);
        chk("t4_addr0", cap_addr[0], S);
        chk("t4_addr1", cap_addr[1], S);
        chk_sector("t4a", 0, 0, 100);
        chk_sector("t4b", 100, 0, 256);
        chk("t4_sec_cnt", sec_cnt, 32'd1);

        // Sector limit
        do_reset();
        w_en = 1'b1;
        feed(0, 2048, 0, 6000);
        wait_sectors("t5_wait", 3, 6000);
        repeat (10) @(negedge clk_sd);
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_sec_cnt", sec_cnt, 32'd3);
        chk("t5_ready_low", 32'(din_ready), 32'd0);
        chk("t5_addr", wr_sec_addr, S + 32'd3);
        repeat (200) @(negedge clk_sd);
        chk("t5_no_more_start", 32'(w_starts), 32'd3);
        chk("t5_start_low", 32'(wr_start_en), 32'd0);

`ifdef SD_SECBUF_FLUSH_EN
        // Flush of a partial sector
        do_reset();
        w_en = 1'b1;
        din = 8'hA1; din_valid = 1'b1;
        @(negedge clk_sd) din = 8'hB2;
        @(negedge clk_sd) din = 8'hC3;
        @(negedge clk_sd) begin din_valid = 1'b0; flush = 1'b1; end
        @(negedge clk_sd) flush = 1'b0;
        chk("t6_flush_busy", 32'(flush_busy), 32'd1);
        chk("t6_ready_forced", 32'(din_ready), 32'd0);
        t = 0;
        for (int k = 0; k < 2000 && flush_busy; k++) begin
            t++;
            @(negedge clk_sd);
        end
        chk("t6_flush_cycles", 32'(t), 32'd509);
        wait_sectors("t6_wait", 1, 3000);
        chk("t6_addr", cap_addr[0], S);
        chk("t6_w0", 32'(cap_w[0]), 32'h0000_A1B2);
        chk("t6_w1", 32'(cap_w[1]), 32'h0000_C3FF);
        t = 0;
        for (int k = 2; k < 256 && k < cap_w.size(); k++)
            if (cap_w[k] !== 16'hFFFF) t++;
        chk("t6_pad_bad", 32'(t), 32'd0);
        flush = 1'b1;
        @(negedge clk_sd) flush = 1'b0;
        chk("t6_noop_busy", 32'(flush_busy), 32'd0);
        chk("t6_noop_ready", 32'(din_ready), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
